pwm_gen: RTL and testbench

Carrier-based PWM generator fed by the MPPT up/down duty counter. It consumes the 6-bit duty word `cnt` and clamps it to a safe range. The word is latched only at carrier period boundaries. The block drives complementary high-side/low-side gate signals with a programmable dead time, and emits a period tick that paces the upstream perturb-and-observe sequencing.

---
 rtl/mppt_pkg.sv | 17 +
 rtl/dead_time_gen.sv | 45 ++++
 rtl/pwm_gen.sv | 57 +++++
 tb/tb_pwm_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mppt_pkg.sv
// rtl/mppt_pkg.sv - shared MPPT constants and duty clamp helper
package mppt_pkg;
  localparam int DUTY_W   = 6;
  localparam int PERIOD   = 46;
  localparam int DC_RESET = 23;
  localparam int DEADTIME = 2;
  localparam int DMIN     = 3;
  localparam int DMAX     = 43;

  typedef logic [DUTY_W-1:0] duty_t;

  function automatic duty_t clamp_duty(input duty_t v, input duty_t dmin, input duty_t dmax);
    if (v < dmin) return dmin;
    if (v > dmax) return dmax;
    return v;
  endfunction
endpackage

// File: rtl/dead_time_gen.sv
// rtl/dead_time_gen.sv - complementary gate driver with dead-time insertion
module dead_time_gen #(
  parameter int DEADTIME = mppt_pkg::DEADTIME
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic t,
  output logic pwm_h,
  output logic pwm_l
);
  import mppt_pkg::*;

  localparam duty_t DT_LOAD = duty_t'(DEADTIME - 1);

  logic  side;
  duty_t dt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      side  <= 1'b0;
      dt    <= DT_LOAD;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else if (!run) begin
      side  <= 1'b0;
      dt    <= DT_LOAD;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else if (t != side) begin
      // a target flip during dead time simply restarts the dead interval
      side  <= t;
      dt    <= DT_LOAD;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else if (dt != '0) begin
      dt    <= dt - 1'b1;
      pwm_h <= 1'b0;
      pwm_l <= 1'b0;
    end else begin
      pwm_h <= side;
      pwm_l <= ~side;
    end
  end
endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - carrier PWM with clamped shadow duty and period tick
module pwm_gen #(
  parameter int PERIOD   = mppt_pkg::PERIOD,
  parameter int DEADTIME = mppt_pkg::DEADTIME,
  parameter int DMIN     = mppt_pkg::DMIN,
  parameter int DMAX     = mppt_pkg::DMAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] cnt,
  output logic       pwm_h,
  output logic       pwm_l,
  output logic       period_tick,
  output logic [5:0] duty_q
);
  import mppt_pkg::*;

  localparam duty_t CAR_LAST = duty_t'(PERIOD - 1);

  duty_t car;
  duty_t dc;
  logic  wrap;
  logic  t;

  assign dc   = clamp_duty(cnt, duty_t'(DMIN), duty_t'(DMAX));
  assign wrap = (car == CAR_LAST);
  assign t    = (car < duty_q);

  // duty_q only moves at the period boundary so a period is never split
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car         <= '0;
      duty_q      <= duty_t'(DC_RESET);
      period_tick <= 1'b0;
    end else if (!run) begin
      car         <= '0;
      duty_q      <= dc;
      period_tick <= 1'b0;
    end else begin
      car         <= wrap ? '0 : car + 1'b1;
      period_tick <= wrap;
      if (wrap) duty_q <= dc;
    end
  end

  dead_time_gen #(
    .DEADTIME(DEADTIME)
  ) u_dead_time (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .t    (t),
    .pwm_h(pwm_h),
    .pwm_l(pwm_l)
  );
endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - randomized check of pwm_gen against a per-position waveform model
module tb_pwm_gen;
  localparam int P   = 46;
  localparam int DT  = 2;
  localparam int DMN = 3;
  localparam int DMX = 43;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [5:0] cnt;
  logic       pwm_h;
  logic       pwm_l;
  logic       period_tick;
  logic [5:0] duty_q;

  int tests = 0;
  int fails = 0;

  // model state: carrier position about to be evaluated and duty in force
  int mc = 0;
  int md = 23;
  int hcnt = 0, lcnt = 0, pduty = 0;
  bit pvalid = 0;

  always #5 clk = ~clk;

  pwm_gen dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .cnt        (cnt),
    .pwm_h      (pwm_h),
    .pwm_l      (pwm_l),
    .period_tick(period_tick),
    .duty_q     (duty_q)
  );

  function automatic int ref_clamp(input int v);
    if (v < DMN) return DMN;
    if (v > DMX) return DMX;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // one clock: predict gates from carrier position and duty, then compare
  task automatic step();
    int  c, d;
    bit  eh, el, et;
    @(posedge clk);
    eh = 0; el = 0; et = 0;
    if (rst) begin
      mc = 0; md = 23; pvalid = 0;
    end else if (!run) begin
      mc = 0; md = ref_clamp(cnt); pvalid = 0;
    end else begin
      c  = mc;
      d  = md;
      eh = (c >= DT) && (c < d);
      el = (c >= d + DT) && (c < P);
      et = (c == P - 1);
      if (c == 0) begin
        hcnt = 0; lcnt = 0; pvalid = 1; pduty = d;
      end
      hcnt += int'(eh);
      lcnt += int'(el);
      if (c == P - 1) md = ref_clamp(cnt);
      mc = (c + 1) % P;
    end
    #1;
    chk("pwm_h", pwm_h, eh);
    chk("pwm_l", pwm_l, el);
    chk("period_tick", period_tick, et);
    chk("duty_q", duty_q, md);
    chk("no_overlap", pwm_h & pwm_l, 0);
    if (et && pvalid) begin
      chk("h_width", hcnt, pduty - DT);
      chk("l_width", lcnt, P - pduty - DT);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b0; cnt = 6'd23;
    #12;
    chk("rst_pwm_h", pwm_h, 0);
    chk("rst_pwm_l", pwm_l, 0);
    chk("rst_tick", period_tick, 0);
    chk("rst_duty", duty_q, 23);
    repeat (2) step();

    @(negedge clk);
    rst = 1'b0; run = 1'b1;
    repeat (3 * P) step();

    cnt = 6'd60;
    repeat (3 * P) step();
    cnt = 6'd0;
    repeat (3 * P) step();
    cnt = 6'd23;
    repeat (2 * P) step();

    // request changes mid-period: current period keeps the old duty
    n = 0;
    while (mc != 10 && n < 200) begin step(); n++; end
    chk("wait_car10", n < 200, 1);
    cnt = 6'd30;
    repeat (2 * P) step();

    // asynchronous reset while the high side is on
    cnt = 6'd23;
    n = 0;
    while (pwm_h !== 1'b1 && n < 200) begin step(); n++; end
    chk("wait_pwm_h", pwm_h, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_pwm_h", pwm_h, 0);
    chk("async_pwm_l", pwm_l, 0);
    chk("async_duty", duty_q, 23);
    mc = 0; md = 23; pvalid = 0;
    repeat (2) step();
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * P) step();

    // run dropped mid-period for five cycles
    n = 0;
    while (mc != 20 && n < 200) begin step(); n++; end
    chk("wait_car20", n < 200, 1);
    run = 1'b0;
    cnt = 6'd35;
    repeat (5) step();
    run = 1'b1;
    repeat (2 * P) step();

    // randomized requests and hold intervals
    repeat (40) begin
      cnt = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) begin
        run = 1'b0;
        repeat ($urandom_range(1, 6)) step();
        run = 1'b1;
      end
      repeat ($urandom_range(1, 60)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
